// File: rtl/req_tag_arbiter.sv
// req_tag_arbiter: shares the 16-entry Request Recorder and its PCIe tag space
// between the AXI AW and AR request paths. Each grant allocates the lowest
// free tag and writes {id, valid} to the recorder. Tags are returned by the
// completion side through free_en/free_tag.
// Optional build macro TAG_ERR_CHECK_EN adds a sticky tag_err output that
// flags frees of tags that are not currently allocated.
module req_tag_arbiter #(
  parameter int TAG_WIDTH = 4,
  parameter int ID_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   aw_req,
  input  logic [ID_WIDTH-1:0]    aw_id,
  output logic                   aw_grant,
  output logic [TAG_WIDTH-1:0]   aw_tag,
  input  logic                   ar_req,
  input  logic [ID_WIDTH-1:0]    ar_id,
  output logic                   ar_grant,
  output logic [TAG_WIDTH-1:0]   ar_tag,
  output logic                   rec_wr_en,
  output logic [TAG_WIDTH-1:0]   rec_wr_addr,
  output logic [ID_WIDTH:0]      rec_wr_data,
  input  logic                   free_en,
  input  logic [TAG_WIDTH-1:0]   free_tag,
  output logic [TAG_WIDTH:0]     outstanding,
  output logic                   full,
  output logic                   empty
`ifdef TAG_ERR_CHECK_EN
  , output logic                 tag_err
`endif
);

  localparam int DEPTH = 2 ** TAG_WIDTH;
  localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]     free_vec;
  logic                 rr_last;          // 1 = AR won the last grant
  logic                 aw_elig_p0;
  logic                 ar_elig_p0;
  logic                 any_free_p0;
  logic [TAG_WIDTH-1:0] tag_p0;
  logic                 aw_win_p0;
  logic                 ar_win_p0;
  logic                 vld_p0;
  logic                 valid_free_p0;
  logic [ID_WIDTH-1:0]  id_p0;

  // A requester holding req while its grant pulse is high is not eligible, so
  // it cannot be granted twice for one request.
  assign aw_elig_p0  = aw_req & ~aw_grant;
  assign ar_elig_p0  = ar_req & ~ar_grant;
  assign any_free_p0 = |free_vec;

  // On a tie, the side that did not win last time gets the grant.
  assign aw_win_p0 = aw_elig_p0 & any_free_p0 & (~ar_elig_p0 | rr_last);
  assign ar_win_p0 = ar_elig_p0 & any_free_p0 & (~aw_elig_p0 | ~rr_last);
  assign vld_p0    = aw_win_p0 | ar_win_p0;
  assign id_p0     = ar_win_p0 ? ar_id : aw_id;

  // Only a tag that is currently allocated may be released. Because tag_p0 is
  // taken from the free vector at the start of the cycle, a tag released in
  // this cycle cannot be allocated until the next cycle.
  assign valid_free_p0 = free_en & ~free_vec[free_tag];

  // Lowest-index free tag; scanning from the top lets the lowest hit win.
  always_comb begin
    tag_p0 = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) tag_p0 = i[TAG_WIDTH-1:0];
    end
  end

  // ---- stage boundary: registered grant, recorder write and tag bookkeeping
  // Grant stage, free vector, round-robin pointer and occupancy counter.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      free_vec    <= '1;
      rr_last     <= 1'b0;
      aw_grant    <= 1'b0;
      ar_grant    <= 1'b0;
      aw_tag      <= '0;
      ar_tag      <= '0;
      rec_wr_en   <= 1'b0;
      rec_wr_addr <= '0;
      rec_wr_data <= '0;
      outstanding <= '0;
    end else begin
      aw_grant  <= aw_win_p0;
      ar_grant  <= ar_win_p0;
      rec_wr_en <= vld_p0;
      if (vld_p0) begin
        rr_last     <= ar_win_p0;
        rec_wr_addr <= tag_p0;
        rec_wr_data <= {id_p0, 1'b1};
      end
      if (aw_win_p0) aw_tag <= tag_p0;
      if (ar_win_p0) ar_tag <= tag_p0;
      free_vec <= (free_vec & ~(vld_p0 ? (ONE_HOT0 << tag_p0) : '0))
                | (valid_free_p0 ? (ONE_HOT0 << free_tag) : '0);
      // An allocation and a release in the same cycle cancel; neither path
      // can move the count past 0 or DEPTH, so it never wraps.
      case ({vld_p0, valid_free_p0})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign full  = (outstanding == (TAG_WIDTH + 1)'(DEPTH));
  assign empty = (outstanding == '0);

`ifdef TAG_ERR_CHECK_EN
  // Sticky flag for a free of a tag that is not allocated. DEPTH always equals
  // 2**TAG_WIDTH here, so an out-of-range free_tag cannot occur.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) tag_err <= 1'b0;
    else if (free_en & free_vec[free_tag]) tag_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_req_tag_arbiter.sv
// Directed bench for req_tag_arbiter. Expected per-cycle results are queued
// when the stimulus is driven and compared after the following clock edge.
module tb_req_tag_arbiter;

  logic       clk = 1'b0;
  logic       arst;
  logic       aw_req, ar_req, free_en;
  logic [7:0] aw_id, ar_id;
  logic [3:0] free_tag;
  logic       aw_grant, ar_grant, rec_wr_en, full, empty;
  logic [3:0] aw_tag, ar_tag, rec_wr_addr;
  logic [8:0] rec_wr_data;
  logic [4:0] outstanding;
`ifdef TAG_ERR_CHECK_EN
  logic       tag_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       aw_g;
    logic       ar_g;
    logic [3:0] tag;
    logic [7:0] id;
    logic [4:0] outs;
  } exp_t;
  exp_t sb[$];

  req_tag_arbiter #(.TAG_WIDTH(4), .ID_WIDTH(8)) dut (
    .clk(clk), .arst(arst),
    .aw_req(aw_req), .aw_id(aw_id), .aw_grant(aw_grant), .aw_tag(aw_tag),
    .ar_req(ar_req), .ar_id(ar_id), .ar_grant(ar_grant), .ar_tag(ar_tag),
    .rec_wr_en(rec_wr_en), .rec_wr_addr(rec_wr_addr), .rec_wr_data(rec_wr_data),
    .free_en(free_en), .free_tag(free_tag),
    .outstanding(outstanding), .full(full), .empty(empty)
`ifdef TAG_ERR_CHECK_EN
    , .tag_err(tag_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then
  // compare it just after the edge.
  task automatic cyc(input logic awr, input logic [7:0] awi,
                     input logic arr, input logic [7:0] ari,
                     input logic fe, input logic [3:0] ft,
                     input logic eaw, input logic ear,
                     input logic [3:0] etag, input logic [7:0] eid,
                     input logic [4:0] eout);
    exp_t e;
    aw_req = awr; aw_id = awi; ar_req = arr; ar_id = ari;
    free_en = fe; free_tag = ft;
    e.aw_g = eaw; e.ar_g = ear; e.tag = etag; e.id = eid; e.outs = eout;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("aw_grant", 32'(aw_grant), 32'(e.aw_g));
    chk("ar_grant", 32'(ar_grant), 32'(e.ar_g));
    chk("rec_wr_en", 32'(rec_wr_en), 32'(e.aw_g | e.ar_g));
    chk("outstanding", 32'(outstanding), 32'(e.outs));
    chk("full", 32'(full), 32'(e.outs == 5'd16));
    chk("empty", 32'(empty), 32'(e.outs == 5'd0));
    if (e.aw_g) chk("aw_tag", 32'(aw_tag), 32'(e.tag));
    if (e.ar_g) chk("ar_tag", 32'(ar_tag), 32'(e.tag));
    if (e.aw_g | e.ar_g) begin
      chk("rec_wr_addr", 32'(rec_wr_addr), 32'(e.tag));
      chk("rec_wr_data", 32'(rec_wr_data), 32'({e.id, 1'b1}));
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_aw_grant", 32'(aw_grant), 32'd0);
    chk("rst_ar_grant", 32'(ar_grant), 32'd0);
    chk("rst_rec_wr_en", 32'(rec_wr_en), 32'd0);
    chk("rst_aw_tag", 32'(aw_tag), 32'd0);
    chk("rst_ar_tag", 32'(ar_tag), 32'd0);
    chk("rst_rec_wr_addr", 32'(rec_wr_addr), 32'd0);
    chk("rst_rec_wr_data", 32'(rec_wr_data), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
`ifdef TAG_ERR_CHECK_EN
    chk("rst_tag_err", 32'(tag_err), 32'd0);
`endif
  endtask

  // Assert reset asynchronously, check outputs before any clock edge, release.
  task automatic do_reset();
    aw_req = 0; ar_req = 0; free_en = 0; aw_id = 0; ar_id = 0; free_tag = 0;
    #2 arst = 1'b0;
    #1 chk_reset_outputs();
    @(posedge clk); #1;
    arst = 1'b1;
  endtask

  initial begin
    arst = 1'b1;
    aw_req = 0; ar_req = 0; free_en = 0; aw_id = 0; ar_id = 0; free_tag = 0;
    #1 arst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outputs();
    arst = 1'b1;

    // Single AW request: tag 0, recorder data {0x3C,1} = 0x079.
    cyc(1, 8'h3C, 0, 8'h00, 0, 4'd0, 1, 0, 4'd0, 8'h3C, 5'd1);
    // req still high while grant pulses: no second grant.
    cyc(1, 8'h3C, 0, 8'h00, 0, 4'd0, 0, 0, 4'd0, 8'h00, 5'd1);
    cyc(0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0, 4'd0, 8'h00, 5'd1);

    // Reset mid-operation returns every tag.
    do_reset();

    // Both held: AR first after reset, then strict alternation up to full.
    for (int k = 0; k < 16; k++)
      cyc(1, 8'hA0, 1, 8'hB0, 0, 4'd0, k[0], ~k[0], k[3:0],
          k[0] ? 8'hA0 : 8'hB0, 5'(k + 1));
    // Full: requests stay pending without grants.
    cyc(1, 8'hA0, 1, 8'hB0, 0, 4'd0, 0, 0, 4'd0, 8'h00, 5'd16);
    cyc(1, 8'hA0, 1, 8'hB0, 0, 4'd0, 0, 0, 4'd0, 8'h00, 5'd16);
    // Release tag 5 while full: not re-granted in the same cycle.
    cyc(1, 8'hA0, 1, 8'hB0, 1, 4'd5, 0, 0, 4'd0, 8'h00, 5'd15);
    // Next cycle the freed tag goes to AR (AW won last).
    cyc(1, 8'hA0, 1, 8'hB0, 0, 4'd0, 0, 1, 4'd5, 8'hB0, 5'd16);
    cyc(0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0, 4'd0, 8'h00, 5'd16);

    do_reset();

    // Build outstanding = 3 from AW alone (granted at most every other cycle).
    cyc(1, 8'h21, 0, 8'h00, 0, 4'd0, 1, 0, 4'd0, 8'h21, 5'd1);
    cyc(1, 8'h21, 0, 8'h00, 0, 4'd0, 0, 0, 4'd0, 8'h00, 5'd1);
    cyc(1, 8'h22, 0, 8'h00, 0, 4'd0, 1, 0, 4'd1, 8'h22, 5'd2);
    cyc(1, 8'h22, 0, 8'h00, 0, 4'd0, 0, 0, 4'd0, 8'h00, 5'd2);
    cyc(1, 8'h23, 0, 8'h00, 0, 4'd0, 1, 0, 4'd2, 8'h23, 5'd3);
    // Grant and release of tag 1 together: count stays 3, tag 3 allocated.
    cyc(0, 8'h00, 1, 8'h55, 1, 4'd1, 0, 1, 4'd3, 8'h55, 5'd3);
    // Freed tag 1 is now the lowest free tag.
    cyc(1, 8'h11, 0, 8'h00, 0, 4'd0, 1, 0, 4'd1, 8'h11, 5'd4);
    // Spurious free of tag 9: no effect on the count.
    cyc(0, 8'h00, 0, 8'h00, 1, 4'd9, 0, 0, 4'd0, 8'h00, 5'd4);
`ifdef TAG_ERR_CHECK_EN
    chk("tag_err_set", 32'(tag_err), 32'd1);
`endif
    cyc(0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0, 4'd0, 8'h00, 5'd4);
`ifdef TAG_ERR_CHECK_EN
    chk("tag_err_sticky", 32'(tag_err), 32'd1);
`endif
    // Tag 9 is still unallocated after the spurious free; a valid free of
    // tag 3 brings the count down.
    cyc(0, 8'h00, 0, 8'h00, 1, 4'd3, 0, 0, 4'd0, 8'h00, 5'd3);

    do_reset();
    cyc(0, 8'h00, 1, 8'h7E, 0, 4'd0, 0, 1, 4'd0, 8'h7E, 5'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
